// File: rtl/dtc_pkg.sv
// Shared DTC definitions: FSM state encoding, counter sizing and the default
// LSB/hold/return-to-zero timing shared with the TDC decoder side.
package dtc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_COUNT,
    ST_HOLD,
    ST_RTZ
  } dtc_state_t;

  localparam int DEL_UNIT = 1;
  localparam int DEL_HOLD = 2;
  localparam int DEL_RTZ  = 2;

  // Wide enough for the largest code scaled by UNIT, with one spare bit.
  function automatic int DTC_CNT_W(input int width, input int unit);
    return width + $clog2(unit) + 1;
  endfunction

endpackage

// File: rtl/dtc_edge_gen_if.sv
// Code handshake between a sender (master) and the DTC edge generator (slave).
interface dtc_edge_gen_if #(
  parameter int WIDTH = 8
);
  logic             code_valid;
  logic             code_ready;
  logic [WIDTH-1:0] code;
  logic             lead;

  modport master (output code_valid, output code, output lead, input code_ready);
  modport slave  (input code_valid, input code, input lead, output code_ready);
endinterface

// File: rtl/dtc_buf1.sv
// One-entry holding register for {code,lead}; ready whenever the slot is empty
// and the block has seen at least one clock since reset.
module dtc_buf1 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  dtc_edge_gen_if.slave    in_if,
  input  logic             pop,
  output logic             buf_full,
  output logic [WIDTH-1:0] buf_code,
  output logic             buf_lead
);

  logic armed;
  logic push;

  assign in_if.code_ready = armed & ~buf_full;
  assign push             = in_if.code_valid & in_if.code_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed    <= 1'b0;
      buf_full <= 1'b0;
    end else begin
      armed    <= 1'b1;
      buf_full <= push | (buf_full & ~pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_code <= in_if.code;
      buf_lead <= in_if.lead;
    end
  end

endmodule

// File: rtl/dtc_edge_gen.sv
// DTC transmitter: emits a ref/data rising-edge pair separated by code*UNIT
// cycles, holds both high, then returns both to zero before the next launch.
module dtc_edge_gen
  import dtc_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int UNIT     = DEL_UNIT,
  parameter int HOLD_CYC = DEL_HOLD,
  parameter int RTZ_CYC  = DEL_RTZ
) (
  input  logic          clk,
  input  logic          rst,
  dtc_edge_gen_if.slave code_if,
  output logic          edge_ref,
  output logic          edge_dat,
  output logic          busy,
  output logic          done
);

  localparam int CNT_W_CODE = DTC_CNT_W(WIDTH, UNIT);
  localparam int CNT_W_TMR  = $clog2(((HOLD_CYC > RTZ_CYC) ? HOLD_CYC : RTZ_CYC) + 1);
  localparam int CNT_W      = (CNT_W_CODE > CNT_W_TMR) ? CNT_W_CODE : CNT_W_TMR;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] RTZ_CNT  = CNT_W'(RTZ_CYC);

  dtc_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] launch_cnt;
  logic [WIDTH-1:0] cur_code;
  logic             cur_lead;
  logic             pop;
  logic             buf_full;
  logic [WIDTH-1:0] buf_code;
  logic             buf_lead;

  dtc_buf1 #(.WIDTH(WIDTH)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .in_if    (code_if),
    .pop      (pop),
    .buf_full (buf_full),
    .buf_code (buf_code),
    .buf_lead (buf_lead)
  );

  // The buffer is popped on every transition into LAUNCH.
  assign pop = buf_full & ((state == ST_IDLE) | ((state == ST_RTZ) & (cnt == CNT_ONE)));

  assign launch_cnt = CNT_W'(cur_code) * CNT_W'(UNIT);
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (pop) begin
      cur_code <= buf_code;
      cur_lead <= buf_lead;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      edge_ref <= 1'b0;
      edge_dat <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (buf_full) state <= ST_LAUNCH;
        end
        ST_LAUNCH: begin
          if (cur_lead) edge_dat <= 1'b1;
          else          edge_ref <= 1'b1;
          // A zero code raises the second edge together with the first.
          if (launch_cnt == '0) begin
            edge_ref <= 1'b1;
            edge_dat <= 1'b1;
            cnt      <= HOLD_CNT;
            state    <= ST_HOLD;
          end else begin
            cnt   <= launch_cnt;
            state <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (cnt == CNT_ONE) begin
            edge_ref <= 1'b1;
            edge_dat <= 1'b1;
            cnt      <= HOLD_CNT;
            state    <= ST_HOLD;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        ST_HOLD: begin
          if (cnt == CNT_ONE) begin
            edge_ref <= 1'b0;
            edge_dat <= 1'b0;
            done     <= 1'b1;
            cnt      <= RTZ_CNT;
            state    <= ST_RTZ;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        ST_RTZ: begin
          if (cnt == CNT_ONE) begin
            cnt   <= '0;
            state <= buf_full ? ST_LAUNCH : ST_IDLE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dtc_edge_gen.sv
// Bench for dtc_edge_gen: directed scenarios plus a randomized stream scored
// against a timing model of when each edge pair must appear.
module tb_dtc_edge_gen;
  import dtc_pkg::*;

  localparam int WIDTH = 8;
  localparam int HOLD  = DEL_HOLD;
  localparam int RTZ   = DEL_RTZ;
  localparam int U1    = 1;
  localparam int U4    = 4;
  localparam int NRAND = 1500;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  dtc_edge_gen_if #(.WIDTH(WIDTH)) ifm ();
  dtc_edge_gen_if #(.WIDTH(WIDTH)) if4 ();

  logic edge_ref, edge_dat, busy, done;
  logic edge_ref4, edge_dat4, busy4, done4;

  dtc_edge_gen #(.WIDTH(WIDTH), .UNIT(U1), .HOLD_CYC(HOLD), .RTZ_CYC(RTZ)) dut (
    .clk(clk), .rst(rst), .code_if(ifm),
    .edge_ref(edge_ref), .edge_dat(edge_dat), .busy(busy), .done(done)
  );

  dtc_edge_gen #(.WIDTH(WIDTH), .UNIT(U4), .HOLD_CYC(HOLD), .RTZ_CYC(RTZ)) dut4 (
    .clk(clk), .rst(rst), .code_if(if4),
    .edge_ref(edge_ref4), .edge_dat(edge_dat4), .busy(busy4), .done(done4)
  );

  typedef struct {
    int t_ref;
    int t_dat;
    int t_fall;
  } tx_t;

  tx_t exp_q[$];
  tx_t obs_q[$];
  int  done_q[$];
  int  last_fall = -100;
  int  last_pop  = -100;
  int  last_acc  = -100;
  int  n_checks  = 0;
  int  n_pass    = 0;

  // Timing model: an accepted code launches two cycles after acceptance, but
  // never before the previous pair has finished its return-to-zero time.
  function automatic void model_accept(input int c, input bit l, input int t);
    int  first;
    int  sep;
    tx_t e;
    first    = (t + 2 > last_fall + RTZ + 1) ? t + 2 : last_fall + RTZ + 1;
    sep      = c * U1;
    e.t_ref  = l ? first + sep : first;
    e.t_dat  = l ? first : first + sep;
    e.t_fall = first + sep + HOLD;
    last_fall = e.t_fall;
    last_pop  = first - 1;
    last_acc  = t;
    exp_q.push_back(e);
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    obs_q.delete();
    done_q.delete();
    last_fall = -100;
    last_pop  = -100;
    last_acc  = -100;
  endfunction

  int   m_tref   = -1;
  int   m_tdat   = -1;
  int   mono_err = 0;
  logic m_pr     = 1'b0;
  logic m_pd     = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      m_pr = 1'b0; m_pd = 1'b0; m_tref = -1; m_tdat = -1;
    end else begin
      if (edge_ref && !m_pr) m_tref = cyc;
      if (edge_dat && !m_pd) m_tdat = cyc;
      if ((m_pr && !edge_ref && edge_dat) || (m_pd && !edge_dat && edge_ref)) mono_err++;
      if ((m_pr || m_pd) && !edge_ref && !edge_dat) begin
        tx_t o;
        o.t_ref = m_tref; o.t_dat = m_tdat; o.t_fall = cyc;
        obs_q.push_back(o);
        m_tref = -1; m_tdat = -1;
      end
      if (done) done_q.push_back(cyc);
      m_pr = edge_ref;
      m_pd = edge_dat;
    end
  end

  task automatic push_item(input int c, input bit l, output int t_acc);
    int g = 0;
    @(negedge clk);
    ifm.code = WIDTH'(c); ifm.lead = l; ifm.code_valid = 1'b1;
    while (!ifm.code_ready && g < 5000) begin
      @(negedge clk);
      g++;
    end
    t_acc = cyc + 1;
    model_accept(c, l, t_acc);
  endtask

  task automatic release_valid();
    @(negedge clk);
    ifm.code_valid = 1'b0;
  endtask

  task automatic wait_obs(input int n, input int limit);
    for (int i = 0; i < limit && obs_q.size() < n; i++) @(negedge clk);
    repeat (RTZ + 2) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (edge_ref !== 1'b0) $display("FAIL reset_edge_ref got %b exp 0", edge_ref); else n_pass++;
    n_checks++; if (edge_dat !== 1'b0) $display("FAIL reset_edge_dat got %b exp 0", edge_dat); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else n_pass++;
    n_checks++; if (ifm.code_ready !== 1'b0) $display("FAIL reset_ready got %b exp 0", ifm.code_ready); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (ifm.code_ready !== 1'b1) $display("FAIL post_reset_ready got %b exp 1", ifm.code_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL post_reset_busy got %b exp 0", busy); else n_pass++;
  endtask

  task automatic test_code_zero();
    int  t;
    tx_t o;
    push_item(0, 1'b0, t);
    release_valid();
    wait_obs(1, 50);
    n_checks++; if (obs_q.size() !== 1) $display("FAIL zero_count got %0d exp 1", obs_q.size()); else n_pass++;
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      void'(exp_q.pop_front());
      n_checks++; if (o.t_ref !== t + 2) $display("FAIL zero_ref_rise got %0d exp %0d", o.t_ref, t + 2); else n_pass++;
      n_checks++; if (o.t_dat !== t + 2) $display("FAIL zero_dat_rise got %0d exp %0d", o.t_dat, t + 2); else n_pass++;
      n_checks++; if (o.t_fall !== t + 2 + HOLD) $display("FAIL zero_fall got %0d exp %0d", o.t_fall, t + 2 + HOLD); else n_pass++;
    end
    n_checks++;
    if (done_q.size() !== 1 || done_q[0] !== t + 2 + HOLD)
      $display("FAIL zero_done got count %0d exp single pulse at %0d", done_q.size(), t + 2 + HOLD);
    else n_pass++;
    done_q.delete();
  endtask

  task automatic test_code_five();
    int  t1, t2;
    tx_t o, e;
    push_item(5, 1'b0, t1);
    push_item(5, 1'b1, t2);
    release_valid();
    wait_obs(2, 100);
    n_checks++; if (obs_q.size() !== 2) $display("FAIL five_count got %0d exp 2", obs_q.size()); else n_pass++;
    if (obs_q.size() > 1) begin
      o = obs_q.pop_front();
      void'(exp_q.pop_front());
      n_checks++; if (o.t_ref !== t1 + 2) $display("FAIL five_ref_rise got %0d exp %0d", o.t_ref, t1 + 2); else n_pass++;
      n_checks++; if (o.t_dat !== t1 + 7) $display("FAIL five_dat_rise got %0d exp %0d", o.t_dat, t1 + 7); else n_pass++;
      n_checks++; if (done_q[0] !== t1 + 9) $display("FAIL five_done got %0d exp %0d", done_q[0], t1 + 9); else n_pass++;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_checks++; if (o.t_ref - o.t_dat !== 5) $display("FAIL five_lead_sep got %0d exp 5", o.t_ref - o.t_dat); else n_pass++;
      n_checks++; if (o.t_dat !== e.t_dat) $display("FAIL five_lead_launch got %0d exp %0d", o.t_dat, e.t_dat); else n_pass++;
    end
    obs_q.delete(); exp_q.delete(); done_q.delete();
  endtask

  task automatic test_back_to_back();
    int  t1, t2, t3;
    int  seps[3];
    tx_t o[3];
    seps[0] = 3; seps[1] = 7; seps[2] = 1;
    push_item(3, 1'b0, t1);
    push_item(7, 1'b0, t2);
    @(negedge clk);
    n_checks++; if (ifm.code_ready !== 1'b0) $display("FAIL b2b_ready_full got %b exp 0", ifm.code_ready); else n_pass++;
    push_item(1, 1'b0, t3);
    release_valid();
    wait_obs(3, 200);
    n_checks++; if (obs_q.size() !== 3) $display("FAIL b2b_count got %0d exp 3", obs_q.size()); else n_pass++;
    if (obs_q.size() > 2 && done_q.size() > 2) begin
      for (int i = 0; i < 3; i++) o[i] = obs_q.pop_front();
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (o[i].t_dat - o[i].t_ref !== seps[i])
          $display("FAIL b2b_sep%0d got %0d exp %0d", i, o[i].t_dat - o[i].t_ref, seps[i]);
        else n_pass++;
      end
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (o[i+1].t_ref - done_q[i] !== RTZ + 1)
          $display("FAIL b2b_gap%0d got %0d exp %0d", i, o[i+1].t_ref - done_q[i], RTZ + 1);
        else n_pass++;
      end
    end
    obs_q.delete(); exp_q.delete(); done_q.delete();
  endtask

  task automatic test_unit4();
    int t = 0, tr = -1, td = -1, tdn = -1, g = 0;
    @(negedge clk);
    if4.code = 8'd255; if4.lead = 1'b0; if4.code_valid = 1'b1;
    while (!if4.code_ready && g < 50) begin @(negedge clk); g++; end
    t = cyc + 1;
    @(negedge clk);
    if4.code_valid = 1'b0;
    for (int i = 0; i < 1200 && tdn < 0; i++) begin
      if (edge_ref4 && tr < 0) tr = cyc;
      if (edge_dat4 && td < 0) td = cyc;
      if (done4 && tdn < 0) tdn = cyc;
      if (tdn < 0) @(negedge clk);
    end
    n_checks++; if (tr !== t + 2) $display("FAIL u4_ref_rise got %0d exp %0d", tr, t + 2); else n_pass++;
    n_checks++; if (td - tr !== 255 * U4) $display("FAIL u4_sep got %0d exp %0d", td - tr, 255 * U4); else n_pass++;
    n_checks++; if (tdn !== td + HOLD) $display("FAIL u4_done got %0d exp %0d", tdn, td + HOLD); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int  t, tf = -1;
    tx_t o;
    push_item(20, 1'b0, t);
    release_valid();
    for (int i = 0; i < 20 && tf < 0; i++) begin
      @(negedge clk);
      if (edge_ref) tf = cyc;
    end
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (edge_ref !== 1'b1) $display("FAIL mid_pre_ref got %b exp 1", edge_ref); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (edge_ref !== 1'b0) $display("FAIL mid_rst_ref got %b exp 0", edge_ref); else n_pass++;
    n_checks++; if (edge_dat !== 1'b0) $display("FAIL mid_rst_dat got %b exp 0", edge_dat); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL mid_rst_busy got %b exp 0", busy); else n_pass++;
    n_checks++; if (ifm.code_ready !== 1'b0) $display("FAIL mid_rst_ready got %b exp 0", ifm.code_ready); else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    n_checks++; if (ifm.code_ready !== 1'b1) $display("FAIL mid_after_ready got %b exp 1", ifm.code_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL mid_after_busy got %b exp 0", busy); else n_pass++;
    push_item(3, 1'b0, t);
    release_valid();
    wait_obs(1, 50);
    n_checks++; if (obs_q.size() !== 1) $display("FAIL mid_next_count got %0d exp 1", obs_q.size()); else n_pass++;
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      n_checks++;
      if (o.t_ref !== t + 2 || o.t_dat !== t + 5 || o.t_fall !== t + 5 + HOLD)
        $display("FAIL mid_next_pair got %0d/%0d/%0d exp %0d/%0d/%0d",
                 o.t_ref, o.t_dat, o.t_fall, t + 2, t + 5, t + 5 + HOLD);
      else n_pass++;
    end
    obs_q.delete(); exp_q.delete(); done_q.delete();
  endtask

  task automatic test_random();
    int  issued = 0, sent = 0, stall = 0, guard = 0;
    bit  pend = 1'b0;
    bit  exp_rdy;
    tx_t o, e;
    int  d;
    while (sent < NRAND && guard < 90000) begin
      @(negedge clk);
      guard++;
      if (pend) begin
        pend = 1'b0;
        sent++;
        ifm.code_valid = 1'b0;
        stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0;
      end
      if (!ifm.code_valid && issued < NRAND) begin
        if (stall > 0) stall--;
        else begin
          ifm.code = ($urandom_range(0, 49) == 0) ? WIDTH'($urandom_range(0, 255))
                                                  : WIDTH'($urandom_range(0, 15));
          ifm.lead = 1'($urandom_range(0, 1));
          ifm.code_valid = 1'b1;
          issued++;
        end
      end
      exp_rdy = !(last_acc <= cyc && cyc < last_pop);
      n_checks++;
      if (ifm.code_ready !== exp_rdy) $display("FAIL rand_ready at %0d got %b exp %b", cyc, ifm.code_ready, exp_rdy);
      else n_pass++;
      if (ifm.code_valid && ifm.code_ready) begin
        model_accept(int'(ifm.code), ifm.lead, cyc + 1);
        pend = 1'b1;
      end
    end
    ifm.code_valid = 1'b0;
    wait_obs(exp_q.size(), 5000);
    n_checks++;
    if (obs_q.size() !== exp_q.size() || exp_q.size() !== NRAND)
      $display("FAIL rand_count got %0d exp %0d (model %0d)", obs_q.size(), NRAND, exp_q.size());
    else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      d = (done_q.size() > 0) ? done_q.pop_front() : -1;
      n_checks++;
      if (o.t_ref !== e.t_ref || o.t_dat !== e.t_dat || o.t_fall !== e.t_fall)
        $display("FAIL rand_pair got %0d/%0d/%0d exp %0d/%0d/%0d",
                 o.t_ref, o.t_dat, o.t_fall, e.t_ref, e.t_dat, e.t_fall);
      else n_pass++;
      n_checks++;
      if (d !== e.t_fall) $display("FAIL rand_done got %0d exp %0d", d, e.t_fall); else n_pass++;
    end
    n_checks++; if (mono_err !== 0) $display("FAIL edge_monotonic got %0d exp 0", mono_err); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    ifm.code_valid = 1'b0; ifm.code = '0; ifm.lead = 1'b0;
    if4.code_valid = 1'b0; if4.code = '0; if4.lead = 1'b0;
    test_reset();
    test_code_zero();
    test_code_five();
    test_back_to_back();
    test_unit4();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
